// File: rtl/reg_write_demux_pkg.sv
// Shared register-bank constants, also used by the matching read mux.
package reg_write_demux_pkg;
  localparam int NUM_REGS = 5;
  localparam int SEL_W    = 3;
  localparam logic [SEL_W-1:0] REG_A = 3'd0;
  localparam logic [SEL_W-1:0] REG_B = 3'd1;
  localparam logic [SEL_W-1:0] REG_C = 3'd2;
  localparam logic [SEL_W-1:0] REG_D = 3'd3;
  localparam logic [SEL_W-1:0] REG_E = 3'd4;

  function automatic logic [NUM_REGS-1:0] sel_onehot(input logic [SEL_W-1:0] s);
    logic [NUM_REGS-1:0] oh;
    for (int k = 0; k < NUM_REGS; k++) oh[k] = (s == SEL_W'(k));
    return oh;
  endfunction
endpackage

// File: rtl/reg_write_demux_if.sv
// Write-request bus: valid/ready handshake carrying destination select and data.
interface reg_write_demux_if
  import reg_write_demux_pkg::*;
#(
  parameter int WIDTH = 16
) ();
  logic             valid;
  logic             ready;
  logic [SEL_W-1:0] sel;
  logic [WIDTH-1:0] data;

  modport master (output valid, sel, data, input ready);
  modport slave  (input valid, sel, data, output ready);
endinterface

// File: rtl/reg_write_demux_sync_fifo.sv
// Single-clock FIFO; count is one bit wider than the pointers so full != empty.
module reg_write_demux_sync_fifo #(
  parameter int W     = 19,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0][W-1:0] mem;
  logic [AW-1:0]           wptr, rptr;
  logic                    do_push, do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/reg_write_demux.sv
// Commits queued (sel, data) write requests into five architectural registers.
module reg_write_demux
  import reg_write_demux_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int DEPTH      = 2,
  parameter int STRICT_SEL = 1
) (
  input  logic                clk,
  input  logic                rst,
  reg_write_demux_if.slave    wr,
  input  logic                hold,
  input  logic                clr_err,
  output logic [WIDTH-1:0]    r0,
  output logic [WIDTH-1:0]    r1,
  output logic [WIDTH-1:0]    r2,
  output logic [WIDTH-1:0]    r3,
  output logic [WIDTH-1:0]    r4,
  output logic [NUM_REGS-1:0] wr_strobe,
  output logic                err_sel,
  output logic [15:0]         wr_cnt,
  output logic                busy
);
  localparam int FW = WIDTH + SEL_W;

  logic [NUM_REGS-1:0][WIDTH-1:0] regs;
  logic [FW-1:0]                  head;
  logic                           full, empty, pop;
  logic [$clog2(DEPTH):0]         count;
  logic [SEL_W-1:0]               head_sel, tgt;
  logic [WIDTH-1:0]               head_data;
  logic                           illegal, write_en, err_set;

  assign wr.ready = !rst && !full;
  assign pop      = !hold && !empty;
  assign busy     = (count != '0);

  reg_write_demux_sync_fifo #(.W(FW), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (wr.valid && wr.ready),
    .pop   (pop),
    .din   ({wr.sel, wr.data}),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  assign head_sel  = head[FW-1 -: SEL_W];
  assign head_data = head[WIDTH-1:0];

  // Out-of-range selects either fault (strict) or alias onto the last register.
  always_comb begin
    illegal  = (head_sel > REG_E);
    tgt      = illegal ? REG_E : head_sel;
    write_en = pop && !(STRICT_SEL != 0 && illegal);
    err_set  = pop && (STRICT_SEL != 0) && illegal;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      regs      <= '0;
      wr_strobe <= '0;
      err_sel   <= 1'b0;
      wr_cnt    <= '0;
    end else begin
      wr_strobe <= write_en ? sel_onehot(tgt) : '0;
      for (int k = 0; k < NUM_REGS; k++)
        if (write_en && tgt == SEL_W'(k)) regs[k] <= head_data;
      if (write_en) wr_cnt <= wr_cnt + 16'd1;
      err_sel <= err_set || (err_sel && !clr_err);
    end
  end

  assign r0 = regs[REG_A];
  assign r1 = regs[REG_B];
  assign r2 = regs[REG_C];
  assign r3 = regs[REG_D];
  assign r4 = regs[REG_E];
endmodule
